// File: rtl/maxpool_window_gen_pkg.sv
// Shared constants for the 2x2 max-pool window interface (producer and consumer).
package maxpool_window_gen_pkg;

    // Channel parallelism and value width of the CNN core
    localparam int unsigned CNN_M_CO   = 1;
    localparam int unsigned CNN_M_CI   = 1;
    localparam int unsigned CNN_MAX_BW = 8;

    // 2x2 window: number of values per channel and their packing slots
    localparam int unsigned MP_WIN = 4;
    localparam int unsigned MP_TL  = 0;
    localparam int unsigned MP_TR  = 1;
    localparam int unsigned MP_BL  = 2;
    localparam int unsigned MP_BR  = 3;

    // Role of an accepted beat, selected by {row[0], col[0]}
    typedef enum logic [1:0] {
        BEAT_PAIR_LO = 2'b00,  // even row, even col: hold left pixel of the pair
        BEAT_PAIR_WR = 2'b01,  // even row, odd col: write the pair to the line buffer
        BEAT_BL      = 2'b10,  // odd row, even col: hold bottom-left pixel
        BEAT_WIN     = 2'b11   // odd row, odd col: window complete
    } beat_role_e;

    // Address/counter width that never collapses to zero bits
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/maxpool_line_buf.sv
// Even-row line buffer storing horizontal pixel pairs: sync write, comb read.
module maxpool_line_buf #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned AW     = 2
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data_c
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Pair write; contents need no reset since every odd row is preceded by a full even row
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Read port is only used on odd rows, so it never collides with a write
    assign rd_data_c = mem_q[rd_addr];

endmodule

// File: rtl/maxpool_window_gen.sv
// Raster pixel stream to non-overlapping 2x2 windows (stride 2) for the max-pool stage.
module maxpool_window_gen
    import maxpool_window_gen_pkg::*;
#(
    parameter int unsigned M_CO   = CNN_M_CO,
    parameter int unsigned M_CI   = CNN_M_CI,
    parameter int unsigned MAX_BW = CNN_MAX_BW,
    parameter int unsigned IMG_W  = 8,
    parameter int unsigned IMG_H  = 8
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             i_in_valid,
    input  logic                             i_in_sof,
    input  logic [M_CO*M_CI*MAX_BW-1:0]      i_in_fmap,
    output logic                             o_ot_max_valid,
    output logic [M_CO*M_CI*MP_WIN*MAX_BW-1:0] o_ot_window,
    output logic                             o_ot_frame_done,
    output logic                             o_ot_sof_err
);

    localparam int unsigned NCH    = M_CO * M_CI;
    localparam int unsigned PX_W   = NCH * MAX_BW;
    localparam int unsigned WIN_W  = PX_W * MP_WIN;
    localparam int unsigned PAIR_W = 2 * PX_W;
    localparam int unsigned DEPTH  = IMG_W / 2;
    localparam int unsigned CW     = clog2_min1(IMG_W);
    localparam int unsigned RW     = clog2_min1(IMG_H);
    localparam int unsigned AW     = clog2_min1(DEPTH);

    logic [CW-1:0]     col_q;
    logic [RW-1:0]     row_q;
    logic [CW-1:0]     cur_col_c;
    logic [RW-1:0]     cur_row_c;
    logic [CW-1:0]     col_nx_c;
    logic [RW-1:0]     row_nx_c;
    logic              col_last_c;
    logic              row_last_c;
    beat_role_e        role_c;
    logic [AW-1:0]     pair_addr_c;
    logic              lb_wr_en_c;
    logic [PAIR_W-1:0] lb_rd_pair_c;
    logic [PX_W-1:0]   pair_lo_q;
    logic [PX_W-1:0]   bl_q;
    logic [WIN_W-1:0]  win_c;

    // Position of the current beat (sof forces (0,0)) and the next position
    always_comb begin
        cur_col_c   = i_in_sof ? '0 : col_q;
        cur_row_c   = i_in_sof ? '0 : row_q;
        col_last_c  = (cur_col_c == CW'(IMG_W - 1));
        row_last_c  = (cur_row_c == RW'(IMG_H - 1));
        col_nx_c    = col_last_c ? '0 : cur_col_c + CW'(1);
        row_nx_c    = cur_row_c;
        if (col_last_c) begin
            row_nx_c = row_last_c ? '0 : cur_row_c + RW'(1);
        end
        role_c      = beat_role_e'({cur_row_c[0], cur_col_c[0]});
        pair_addr_c = AW'(cur_col_c >> 1);
        lb_wr_en_c  = i_in_valid && (role_c == BEAT_PAIR_WR);
    end

    maxpool_line_buf #(
        .DEPTH  (DEPTH),
        .DATA_W (PAIR_W),
        .AW     (AW)
    ) u_line_buf (
        .clk       (clk),
        .wr_en     (lb_wr_en_c),
        .wr_addr   (pair_addr_c),
        .wr_data   ({i_in_fmap, pair_lo_q}),
        .rd_addr   (pair_addr_c),
        .rd_data_c (lb_rd_pair_c)
    );

    // Per-channel window packing: TL/TR from the stored pair, BL held, BR live
    always_comb begin
        win_c = '0;
        for (int unsigned c = 0; c < NCH; c++) begin
            win_c[(MP_WIN*c + MP_TL)*MAX_BW +: MAX_BW] = lb_rd_pair_c[c*MAX_BW +: MAX_BW];
            win_c[(MP_WIN*c + MP_TR)*MAX_BW +: MAX_BW] = lb_rd_pair_c[PX_W + c*MAX_BW +: MAX_BW];
            win_c[(MP_WIN*c + MP_BL)*MAX_BW +: MAX_BW] = bl_q[c*MAX_BW +: MAX_BW];
            win_c[(MP_WIN*c + MP_BR)*MAX_BW +: MAX_BW] = i_in_fmap[c*MAX_BW +: MAX_BW];
        end
    end

    // Pixel holding registers; stale contents are always overwritten before use
    always_ff @(posedge clk) begin
        if (i_in_valid && (role_c == BEAT_PAIR_LO)) begin
            pair_lo_q <= i_in_fmap;
        end
        if (i_in_valid && (role_c == BEAT_BL)) begin
            bl_q <= i_in_fmap;
        end
    end

    // Position counters, sticky sof error and registered window outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_q           <= '0;
            row_q           <= '0;
            o_ot_max_valid  <= 1'b0;
            o_ot_frame_done <= 1'b0;
            o_ot_sof_err    <= 1'b0;
            o_ot_window     <= '0;
        end else begin
            o_ot_max_valid  <= 1'b0;
            o_ot_frame_done <= 1'b0;
            if (i_in_valid) begin
                col_q <= col_nx_c;
                row_q <= row_nx_c;
                if (i_in_sof && ((col_q != '0) || (row_q != '0))) begin
                    o_ot_sof_err <= 1'b1;
                end
                if (role_c == BEAT_WIN) begin
                    o_ot_max_valid  <= 1'b1;
                    o_ot_window     <= win_c;
                    o_ot_frame_done <= col_last_c && row_last_c;
                end
            end
        end
    end

endmodule
